// File: rtl/aib_tx_arb_pkg.sv
// Shared types and widths for the AIB transmit arbiter.
// The flit struct is also used by the Rx-side decoder.
package aib_tx_arb_pkg;

    localparam int AIB_FLIT_W    = 72;
    localparam int AIB_SRC_ID_W  = 2;
    localparam int AIB_PAYLOAD_W = 70;

    typedef struct packed {
        logic [AIB_SRC_ID_W-1:0]  src_id;
        logic [AIB_PAYLOAD_W-1:0] payload;
    } aib_flit_t;

    // Index width for an n-way select; never narrower than 1 bit.
    function automatic int idx_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/aib_rr_arb.sv
// N-way round-robin arbiter; owns the rotating priority pointer.
// Ports: clk/rst, req, en in; gnt (one-hot), gnt_idx, gnt_vld out.
module aib_rr_arb
    import aib_tx_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = idx_w(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld
);

    logic [IW-1:0] rr_ptr;
    logic          found;

    // Search from rr_ptr upward, wrapping at N.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < N; k++) begin
            int s;
            s = int'(rr_ptr) + k;
            if (s >= N) s = s - N;
            if (!found && req[s]) begin
                found   = 1'b1;
                gnt_idx = IW'(s);
            end
        end
    end

    assign gnt_vld = en && found;
    assign gnt     = gnt_vld ? (N'(1) << gnt_idx) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (gnt_vld) begin
            if (int'(gnt_idx) == N - 1)
                rr_ptr <= '0;
            else
                rr_ptr <= gnt_idx + IW'(1);
        end
    end

endmodule

// File: rtl/aib_tx_arb.sv
// Credit-gated round-robin merge of NUM_SRC streams into one flit stream.
// Ports: per-source valid/ready/data, credit return, Tx flit out, crd_err.
module aib_tx_arb
    import aib_tx_arb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int CREDITS = 8
) (
    input  logic                                  i_bus_clk,
    input  logic                                  i_rst,
    input  logic [NUM_SRC-1:0]                    i_src_valid,
    output logic [NUM_SRC-1:0]                    o_src_ready,
    input  logic [NUM_SRC-1:0][AIB_PAYLOAD_W-1:0] i_src_data,
    input  logic                                  i_crd_valid,
    input  logic [AIB_SRC_ID_W-1:0]               i_crd_id,
    output logic                                  o_tx_valid,
    input  logic                                  i_tx_ready,
    output logic [AIB_FLIT_W-1:0]                 o_tx_data,
    output logic                                  o_crd_err
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam int IW = idx_w(NUM_SRC);

    logic [CW-1:0]      credit     [NUM_SRC];
    logic [CW-1:0]      credit_nxt [NUM_SRC];
    logic [NUM_SRC-1:0] elig;
    logic [NUM_SRC-1:0] gnt;
    logic [NUM_SRC-1:0] ret_hit;
    logic [NUM_SRC-1:0] ovf;
    logic [IW-1:0]      gnt_idx;
    logic               gnt_vld;
    logic               load;
    logic               bad_id;
    logic               err_set;
    aib_flit_t          tx_flit;

    assign load = !o_tx_valid || i_tx_ready;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            elig[i]    = i_src_valid[i] && (credit[i] != '0);
            ret_hit[i] = i_crd_valid
                      && (int'(i_crd_id) == i);
            // A same-cycle grant makes room for the return.
            ovf[i]     = ret_hit[i] && !gnt[i]
                      && (credit[i] == CW'(CREDITS));
        end
    end

    aib_rr_arb #(.N(NUM_SRC)) u_arb (
        .clk     (i_bus_clk),
        .rst     (i_rst),
        .req     (elig),
        .en      (load),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign o_src_ready = gnt;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            credit_nxt[i] = credit[i];
            if (ret_hit[i] && !ovf[i] && !gnt[i])
                credit_nxt[i] = credit[i] + CW'(1);
            else if (gnt[i] && !ret_hit[i])
                credit_nxt[i] = credit[i] - CW'(1);
        end
    end

    assign bad_id  = int'(i_crd_id) >= NUM_SRC;
    assign err_set = i_crd_valid && (bad_id || (|ovf));

    always_ff @(posedge i_bus_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_SRC; i++)
                credit[i] <= CW'(CREDITS);
            o_crd_err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++)
                credit[i] <= credit_nxt[i];
            if (err_set)
                o_crd_err <= 1'b1;
        end
    end

    always_ff @(posedge i_bus_clk or posedge i_rst) begin
        if (i_rst) begin
            o_tx_valid <= 1'b0;
            tx_flit    <= '0;
        end else if (load) begin
            o_tx_valid <= gnt_vld;
            if (gnt_vld) begin
                tx_flit.src_id  <= AIB_SRC_ID_W'(gnt_idx);
                tx_flit.payload <= i_src_data[gnt_idx];
            end
        end
    end

    assign o_tx_data = tx_flit;

endmodule

// File: tb/tb_aib_tx_arb.sv
// Self-checking bench for aib_tx_arb against a cycle-level reference model.
// Directed scenarios followed by a randomized phase.
module tb_aib_tx_arb;
    import aib_tx_arb_pkg::*;

    localparam int N  = 4;
    localparam int CR = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [N-1:0]      src_valid;
    logic [N-1:0]      src_ready;
    logic [N-1:0][69:0] src_data;
    logic              crd_valid;
    logic [1:0]        crd_id;
    logic              tx_valid;
    logic              tx_ready;
    logic [71:0]       tx_data;
    logic              crd_err;

    logic [2:0]        v3;
    logic [2:0]        r3;
    logic [2:0][69:0]  d3;
    logic              cv3;
    logic [1:0]        ci3;
    logic              tv3;
    logic [71:0]       td3;
    logic              err3;

    aib_tx_arb #(.NUM_SRC(N), .CREDITS(CR)) dut (
        .i_bus_clk   (clk),
        .i_rst       (rst),
        .i_src_valid (src_valid),
        .o_src_ready (src_ready),
        .i_src_data  (src_data),
        .i_crd_valid (crd_valid),
        .i_crd_id    (crd_id),
        .o_tx_valid  (tx_valid),
        .i_tx_ready  (tx_ready),
        .o_tx_data   (tx_data),
        .o_crd_err   (crd_err)
    );

    aib_tx_arb #(.NUM_SRC(3), .CREDITS(CR)) dut3 (
        .i_bus_clk   (clk),
        .i_rst       (rst),
        .i_src_valid (v3),
        .o_src_ready (r3),
        .i_src_data  (d3),
        .i_crd_valid (cv3),
        .i_crd_id    (ci3),
        .o_tx_valid  (tv3),
        .i_tx_ready  (1'b1),
        .o_tx_data   (td3),
        .o_crd_err   (err3)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(string tag, logic [71:0] got, logic [71:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model state
    int          m_cred[N];
    int          m_rr;
    bit          m_v;
    logic [71:0] m_d;
    bit          m_err;
    int          last_g;
    int          g_cnt[N];

    task automatic m_reset();
        for (int i = 0; i < N; i++) m_cred[i] = CR;
        m_rr  = 0;
        m_v   = 1'b0;
        m_d   = '0;
        m_err = 1'b0;
    endtask

    task automatic clr_cnt();
        for (int i = 0; i < N; i++) g_cnt[i] = 0;
    endtask

    function automatic int m_pick();
        if (m_v && !tx_ready) return -1;
        for (int k = 0; k < N; k++) begin
            int s;
            s = (m_rr + k) % N;
            if (src_valid[s] && m_cred[s] > 0) return s;
        end
        return -1;
    endfunction

    task automatic rand_data();
        for (int i = 0; i < N; i++)
            src_data[i] = 70'({$urandom(), $urandom(), $urandom()});
    endtask

    // Entered at a falling edge with inputs driven; leaves at the next one.
    task automatic cycle();
        int g;
        logic [N-1:0] exp_r;
        #2;
        g = m_pick();
        exp_r = '0;
        if (g >= 0) exp_r[g] = 1'b1;
        chk("src_ready", 72'(src_ready), 72'(exp_r));
        chk("tx_valid", 72'(tx_valid), 72'(m_v));
        chk("tx_data", tx_data, m_d);
        chk("crd_err", 72'(crd_err), 72'(m_err));
        last_g = g;
        if (g >= 0) g_cnt[g]++;
        @(posedge clk);
        if (crd_valid) begin
            int id, room;
            id = int'(crd_id);
            if (id >= N) begin
                m_err = 1'b1;
            end else begin
                room = m_cred[id] - ((g == id) ? 1 : 0);
                if (room + 1 > CR) m_err = 1'b1;
                else m_cred[id]++;
            end
        end
        if (g >= 0) begin
            m_cred[g]--;
            m_rr = (g + 1) % N;
            m_v  = 1'b1;
            m_d  = {2'(g), src_data[g]};
        end else if (!m_v || tx_ready) begin
            m_v = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        src_valid = '0;
        crd_valid = 1'b0;
        cv3       = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_reset();
    endtask

    int exp_ord[6] = '{0, 1, 2, 3, 0, 1};
    logic [71:0] held;

    initial begin
        rst       = 1'b1;
        src_valid = '0;
        crd_valid = 1'b0;
        crd_id    = '0;
        tx_ready  = 1'b1;
        v3        = '0;
        d3        = '0;
        cv3       = 1'b0;
        ci3       = '0;
        last_g    = -1;
        rand_data();
        clr_cnt();
        m_reset();

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_tx_valid", 72'(tx_valid), 72'(0));
        chk("rst_tx_data", tx_data, 72'(0));
        chk("rst_src_ready", 72'(src_ready), 72'(0));
        chk("rst_crd_err", 72'(crd_err), 72'(0));
        rst = 1'b0;

        // Credits from reset: exactly CR flits, then one per return
        src_valid = 4'b0001;
        repeat (14) cycle();
        chk("t1_flits", 72'(g_cnt[0]), 72'(CR));
        crd_valid = 1'b1;
        crd_id    = 2'd0;
        cycle();
        crd_valid = 1'b0;
        repeat (4) cycle();
        chk("t1_extra", 72'(g_cnt[0]), 72'(CR + 1));

        // Round-robin order with credits returned as used
        do_reset();
        src_valid = '1;
        for (int i = 0; i < 6; i++) begin
            rand_data();
            cycle();
            chk("rr_order", 72'(last_g), 72'(exp_ord[i]));
            crd_valid = 1'b1;
            crd_id    = 2'(last_g);
        end
        crd_valid = 1'b0;
        cycle();

        // Backpressure with held data
        for (int i = 0; i < N; i++)
            src_data[i] = {{62{1'b0}}, 8'h3A} | (70'(i) << 60);
        cycle();
        tx_ready = 1'b0;
        held = tx_data;
        repeat (5) begin
            cycle();
            chk("bp_stable", tx_data, held);
        end
        tx_ready = 1'b1;
        repeat (8) cycle();

        // Simultaneous grant and return on source 2
        do_reset();
        src_valid = 4'b0100;
        repeat (5) cycle();
        crd_valid = 1'b1;
        crd_id    = 2'd2;
        cycle();
        chk("t4_grant", 72'(last_g), 72'(2));
        crd_valid = 1'b0;
        clr_cnt();
        repeat (8) cycle();
        chk("t4_drain", 72'(g_cnt[2]), 72'(3));

        // Credit overflow and illegal ID
        do_reset();
        chk("t5_err0", 72'(crd_err), 72'(0));
        crd_valid = 1'b1;
        crd_id    = 2'd1;
        cycle();
        crd_valid = 1'b0;
        cycle();
        chk("t5_ovf_err", 72'(crd_err), 72'(1));
        src_valid = 4'b0010;
        clr_cnt();
        repeat (12) cycle();
        chk("t5_drain", 72'(g_cnt[1]), 72'(CR));
        src_valid = '0;
        chk("t5_err3_0", 72'(err3), 72'(0));
        cv3 = 1'b1;
        ci3 = 2'd3;
        @(negedge clk);
        cv3 = 1'b0;
        #2;
        chk("t5_bad_id", 72'(err3), 72'(1));
        @(negedge clk);

        // Randomized traffic
        do_reset();
        repeat (400) begin
            src_valid = N'($urandom());
            tx_ready  = ($urandom_range(3) != 0);
            crd_valid = ($urandom_range(2) == 0);
            crd_id    = 2'($urandom());
            rand_data();
            cycle();
        end
        crd_valid = 1'b0;

        // Reset with a flit in the output register
        src_valid = '1;
        tx_ready  = 1'b0;
        repeat (2) cycle();
        chk("t6_pre_valid", 72'(tx_valid), 72'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("t6_tx_valid", 72'(tx_valid), 72'(0));
        chk("t6_crd_err", 72'(crd_err), 72'(0));
        chk("t6_tx_data", tx_data, 72'(0));
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        tx_ready = 1'b1;
        clr_cnt();
        cycle();
        chk("t6_first", 72'(last_g), 72'(0));
        repeat (40) cycle();
        for (int i = 0; i < N; i++)
            chk("t6_drain", 72'(g_cnt[i]), 72'(CR));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/aib_tx_arb.md
# aib_tx_arb

Bus-side transmit arbiter that sits directly upstream of the AIB channel Tx datapath (`i_tx_valid` / `o_tx_ready` / `i_tx_data[71:0]`) in the `i_bus_clk` domain. It merges up to four source streams into one 72-bit flit stream using round-robin arbitration. Each flit is tagged with a 2-bit source ID. Per-source credit counters keep the far-side receive buffers from overflowing, and credits are returned by the Rx-side decoder.

## Interface
Parameters:
- `NUM_SRC`, default 4: number of source ports; legal range 2..4.
- `CREDITS`, default 8: initial and maximum credits per source (far-side buffer depth); legal range 1..255.

Ports:
- `i_bus_clk`  in  1: the block's only clock.
- `i_rst`  in  1: reset; asynchronous, active-high.
- `i_src_valid`  in  NUM_SRC: per-source flit valid.
- `o_src_ready`  out  NUM_SRC: per-source accept; one-hot or zero.
- `i_src_data`  in  NUM_SRC x 70: per-source payload.
- `i_crd_valid`  in  1: credit-return strobe; one credit per cycle.
- `i_crd_id`  in  2: source ID whose credit is returned.
- `o_tx_valid`  out  1: flit valid towards the channel.
- `i_tx_ready`  in  1: channel accept.
- `o_tx_data`  out  72: `{src_id[1:0], payload[69:0]}`.
- `o_crd_err`  out  1: sticky credit-overflow or illegal-ID flag.

## Operation
- **Output register.** A single output register holds `o_tx_valid` and `o_tx_data`.
  - `load = !o_tx_valid || i_tx_ready`.
  - On a channel handshake with no new grant, `o_tx_valid` drops to 0.
- **Eligibility.** Source i is eligible when `i_src_valid[i] && credit[i] != 0`.
- **Grant.** When `load` is high and any source is eligible, exactly one is granted.
  - The winner is the first eligible source searching from `rr_ptr` upward, wrapping at NUM_SRC.
  - `o_src_ready[grant] = 1`, and the handshake completes that cycle.
  - `o_src_ready` is combinational from `i_src_valid`, the credits, `rr_ptr` and `load`.
  - Sources must not make `i_src_valid` depend on `o_src_ready`.
- **On each grant:**
  - `rr_ptr <= (grant + 1) mod NUM_SRC`.
  - `credit[grant]` decrements by 1.
  - The output register loads `{grant[1:0], i_src_data[grant]}`.
- **Credit return.** `i_crd_valid` with `i_crd_id = k` increments `credit[k]`.
  - A grant and a return to the same source in the same cycle leave the count unchanged.
  - A return that would exceed `CREDITS`, or that names `k >= NUM_SRC`, is dropped and sets `o_crd_err`. `o_crd_err` clears only on reset.
- **Idle.** With no eligible source, `rr_ptr` holds and no ready is asserted.
- **Credit width.** Counters are `$clog2(CREDITS+1)` bits and never underflow, because a source at 0 credits is ineligible.

## Timing
- **Reset values:**
  - `o_tx_valid = 0`, `o_tx_data = 0`, `o_src_ready = 0`, `o_crd_err = 0`.
  - `rr_ptr = 0`; every `credit[i] = CREDITS`.
- **Latency.** A source handshake in cycle N gives `o_tx_valid = 1` with that flit in cycle N+1.
- **Throughput.** One flit per cycle while `i_tx_ready` is held high.
- **Backpressure.** With `o_tx_valid && !i_tx_ready`, all `o_src_ready` are 0 and `o_tx_data` is stable.
- **Credit timing.** A credit returned in cycle N makes the source eligible in cycle N+1.
- **Reset mid-operation.** Asserting reset with a flit in the output register discards it and restores all credits.
  - The far side must be reset together with this block; this is a system-level requirement.
- **Grant fairness.** Wrap-around `rr_ptr = NUM_SRC-1` with source 0 eligible grants source 0 next. With all NUM_SRC sources eligible and ready held high, grants rotate 0,1,2,3,0,…

## Structure
- **Package `aib_tx_arb_pkg`:**
  - `AIB_FLIT_W = 72`, `AIB_SRC_ID_W = 2`, `AIB_PAYLOAD_W = 70`.
  - Packed struct `aib_flit_t {src_id, payload}`, shared with the Rx-side decoder.
- **Sub-module `aib_rr_arb`:**
  - Parameterised N-way round-robin arbiter.
  - Inputs: request vector and enable. Outputs: one-hot grant and encoded grant index.
  - It owns `rr_ptr`.
- **Top level:** credit counters, error flag and output register.

## Test plan
- **Credits from reset.** Hold source 0 valid with ready high and no returns. Expect exactly 8 flits, each `o_tx_data[71:70] = 0`, then `o_src_ready[0] = 0` indefinitely. One return for ID 0 gives exactly one more flit.
- **Round-robin and wrap.** Hold all four sources valid with ready high and unlimited returns. Expect grant order 0,1,2,3,0,1 and `o_tx_data[71:70]` following it with one-cycle latency.
- **Backpressure.** Drop `i_tx_ready` for 5 cycles with data `0x3A...` held. Expect `o_tx_data` stable, all ready 0, and no lost or duplicated flit after release.
- **Simultaneous grant and return.** At `credit[2] = 3`, grant source 2 and return ID 2 in the same cycle. Expect the count to stay at 3 (check by draining: exactly 3 more flits).
- **Credit errors.** Return ID 1 while it is at 8 credits: expect `o_crd_err = 1` and the count to stay at 8. With NUM_SRC = 3, return ID 3: expect `o_crd_err = 1`.
- **Reset mid-flight.** Assert `i_rst` asynchronously while `o_tx_valid = 1`. Expect immediately `o_tx_valid = 0` and `o_crd_err = 0`; after release, all sources have 8 credits and `rr_ptr = 0`.
